// File: rtl/axi4_lite_cmd_sequencer.sv
// Command FIFO plus a one-transaction-at-a-time issue FSM feeding AXI4_Lite_Master.
// Optional WAIT-state timeout is compiled in when CMD_SEQ_TIMEOUT_EN is defined.
module axi4_lite_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [3:0]                 cmd_addr,
  input  logic [31:0]                cmd_wdata,
  output logic                       transfer,
  output logic [3:0]                 addr,
  output logic [31:0]                wdata,
  output logic                       write,
  input  logic                       ready,
  input  logic [31:0]                rdata,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [3:0]                 rsp_addr,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 37;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_reg;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          full;
  logic          push;
  logic          pop;

  // Full blocks a push even when the FSM pops on the same edge.
  assign full      = (count_reg == CW'(DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign count     = count_reg;
  assign busy      = (state_reg != IDLE) || (count_reg != '0);

  always_ff @(posedge ACLK) begin
    if (push && !ARESET) begin
      mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          rsp_err_reg;
  assign rsp_err = rsp_err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg <= IDLE;
      transfer  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      write     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
`ifdef CMD_SEQ_TIMEOUT_EN
      tmo_cnt_reg <= '0;
      rsp_err_reg <= 1'b0;
`endif
    end else begin
      transfer  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {write, addr, wdata} <= mem[rd_ptr_reg];
            transfer             <= 1'b1;
            state_reg            <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
`ifdef CMD_SEQ_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
        end
        WAIT: begin
          // A ready arriving on the timeout cycle still completes normally.
          if (ready) begin
            rsp_valid <= 1'b1;
            rsp_write <= write;
            rsp_addr  <= addr;
            rsp_rdata <= write ? 32'd0 : rdata;
            state_reg <= RESP;
`ifdef CMD_SEQ_TIMEOUT_EN
            rsp_err_reg <= 1'b0;
          end else if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid   <= 1'b1;
            rsp_write   <= write;
            rsp_addr    <= addr;
            rsp_rdata   <= 32'd0;
            rsp_err_reg <= 1'b1;
            state_reg   <= RESP;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
`endif
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_cmd_sequencer.sv
// Directed bench for axi4_lite_cmd_sequencer with a small master/register-file model.
// The timeout scenario is compiled only when CMD_SEQ_TIMEOUT_EN is defined.
module tb_axi4_lite_cmd_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        transfer;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        write;
  logic        ready;
  logic [31:0] rdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [3:0]  rsp_addr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  logic        manual_mode;
  logic        man_ready;
  logic [31:0] man_rdata;
  logic        auto_ready;
  logic [31:0] auto_rdata;
  logic [31:0] regs [16];

  logic [37:0] rsp_q [$];
  logic [36:0] xfer_q [$];

  assign ready = manual_mode ? man_ready : auto_ready;
  assign rdata = manual_mode ? man_rdata : auto_rdata;

  always #5 ACLK = ~ACLK;

  axi4_lite_cmd_sequencer #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .transfer(transfer), .addr(addr), .wdata(wdata), .write(write),
    .ready(ready), .rdata(rdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_addr(rsp_addr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start_push(input logic w, input logic [3:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  task automatic wait_accept();
    int   n;
    logic acc;
    n = 0;
    do begin
      @(negedge ACLK);
      acc = cmd_ready;
      @(posedge ACLK);
      n++;
    end while (!acc && n < 200);
    #1 cmd_valid = 1'b0;
    check("push_accept", acc, 1'b1);
  endtask

  task automatic push(input logic w, input logic [3:0] a, input logic [31:0] d);
    start_push(w, a, d);
    wait_accept();
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_q.size() < n && k < 400) begin
      tick();
      k++;
    end
    check("rsp_count", rsp_q.size(), n);
  endtask

  // Master / register-file model: answers each transfer two cycles later.
  initial begin
    auto_ready = 1'b0;
    auto_rdata = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    forever begin
      @(negedge ACLK);
      if (transfer && !manual_mode) begin
        if (write) regs[addr] = wdata;
        auto_rdata = regs[addr];
        repeat (2) @(posedge ACLK);
        #1 auto_ready = 1'b1;
        @(posedge ACLK);
        #1 auto_ready = 1'b0;
        auto_rdata = '0;
      end
    end
  end

  // Monitor: logs transfers/responses and checks the command is held while in flight.
  initial begin
    logic        prev_transfer;
    logic        in_flight;
    logic [3:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_write;
    prev_transfer = 1'b0;
    in_flight     = 1'b0;
    cap_addr      = '0;
    cap_wdata     = '0;
    cap_write     = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        in_flight = 1'b0;
      end else begin
        if (transfer) begin
          check("xfer_single", prev_transfer, 1'b0);
          xfer_q.push_back({write, addr, wdata});
          cap_addr  = addr;
          cap_wdata = wdata;
          cap_write = write;
          in_flight = 1'b1;
        end else if (in_flight) begin
          check("addr_stable", addr, cap_addr);
          check("wdata_stable", wdata, cap_wdata);
          check("write_stable", write, cap_write);
        end
        if (rsp_valid) begin
          rsp_q.push_back({rsp_write, rsp_addr, rsp_rdata, rsp_err});
          $display("rsp write=%0d addr=%0d rdata=0x%08h err=%0d t=%0t",
                   rsp_write, rsp_addr, rsp_rdata, rsp_err, $time);
          in_flight = 1'b0;
        end
      end
      prev_transfer = transfer;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int a_tab [4] = '{0, 4, 8, 12};
    int d_tab [4] = '{10, 15, 20, 25};

    ARESET      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    manual_mode = 1'b1;
    man_ready   = 1'b0;
    man_rdata   = '0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Reset state
    @(negedge ACLK);
    check("rst_count", count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_transfer", transfer, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_write", write, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    tick();

    // Single write, manual ready: pop latency, ready ignored in ISSUE, response strobe
    rsp_q.delete(); xfer_q.delete();
    start_push(1'b1, 4'd9, 32'h0000_00A5);
    tick();
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("t1_count_after_push", count, 1);
    check("t1_no_early_transfer", transfer, 0);
    check("t1_busy", busy, 1);
    tick();
    man_ready = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    @(negedge ACLK);
    check("t1_transfer", transfer, 1);
    check("t1_addr", addr, 9);
    check("t1_wdata", wdata, 32'hA5);
    check("t1_count_after_pop", count, 0);
    tick();
    man_ready = 1'b0;
    @(negedge ACLK);
    check("t1_transfer_low", transfer, 0);
    check("t1_ready_in_issue_ignored", rsp_valid, 0);
    tick();
    @(negedge ACLK);
    check("t1_still_waiting", rsp_valid, 0);
    tick();
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    @(negedge ACLK);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_write", rsp_write, 1);
    check("t1_rsp_addr", rsp_addr, 9);
    check("t1_rsp_rdata_write", rsp_rdata, 0);
    tick();
    @(negedge ACLK);
    check("t1_rsp_one_cycle", rsp_valid, 0);
    check("t1_idle_not_busy", busy, 0);
    tick();

    // Four back-to-back writes through the master model
    manual_mode = 1'b0;
    rsp_q.delete(); xfer_q.delete();
    for (int i = 0; i < 4; i++) push(1'b1, 4'(a_tab[i]), 32'(d_tab[i]));
    wait_rsp(4);
    check("t2_xfer_count", xfer_q.size(), 4);
    for (int i = 0; i < 4 && i < rsp_q.size() && i < xfer_q.size(); i++) begin
      check("t2_xfer", xfer_q[i], {1'b1, 4'(a_tab[i]), 32'(d_tab[i])});
      check("t2_rsp", rsp_q[i], {1'b1, 4'(a_tab[i]), 32'd0, 1'b0});
    end
    repeat (3) tick();
    check("t2_idle", busy, 0);

    // Write then read the same register
    rsp_q.delete(); xfer_q.delete();
    push(1'b1, 4'd4, 32'd15);
    push(1'b0, 4'd4, 32'd0);
    wait_rsp(2);
    if (rsp_q.size() >= 2) begin
      check("t3_wr_rsp", rsp_q[0], {1'b1, 4'd4, 32'd0, 1'b0});
      check("t3_rd_rsp", rsp_q[1], {1'b0, 4'd4, 32'd15, 1'b0});
    end
    repeat (3) tick();

    // Fill the FIFO behind a stalled transaction; fifth push waits for the first pop
    manual_mode = 1'b1;
    man_ready   = 1'b0;
    rsp_q.delete(); xfer_q.delete();
    push(1'b1, 4'd0, 32'd100);
    tick(); tick();
    for (int i = 1; i <= 4; i++) push(1'b1, 4'(i), 32'(100 + i));
    @(negedge ACLK);
    check("t4_full_count", count, 4);
    check("t4_full_cmd_ready", cmd_ready, 0);
    tick();
    start_push(1'b1, 4'd5, 32'd105);
    tick(); tick();
    @(negedge ACLK);
    check("t4_push_held_off", count, 4);
    tick();
    man_ready = 1'b1;
    tick();
    man_ready   = 1'b0;
    manual_mode = 1'b0;
    @(negedge ACLK);
    check("t4_rsp_a", rsp_valid, 1);
    check("t4_still_full", cmd_ready, 0);
    tick();
    @(negedge ACLK);
    check("t4_resp_count", count, 4);
    tick();
    @(negedge ACLK);
    check("t4_pop_count", count, 3);
    check("t4_gap_transfer", transfer, 1);
    check("t4_gap_addr", addr, 1);
    tick();
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("t4_fifth_accepted", count, 4);
    wait_rsp(6);
    check("t4_xfer_count", xfer_q.size(), 6);
    for (int i = 0; i < 6 && i < rsp_q.size() && i < xfer_q.size(); i++) begin
      check("t4_xfer", xfer_q[i], {1'b1, 4'(i), 32'(100 + i)});
      check("t4_rsp", rsp_q[i], {1'b1, 4'(i), 32'd0, 1'b0});
    end
    repeat (3) tick();

    // Reset during WAIT with two queued commands; push on the reset edge is dropped
    manual_mode = 1'b1;
    man_ready   = 1'b0;
    rsp_q.delete(); xfer_q.delete();
    push(1'b1, 4'd7, 32'd7);
    tick(); tick();
    push(1'b1, 4'd8, 32'd8);
    push(1'b1, 4'd9, 32'd9);
    @(negedge ACLK);
    check("t5_queued", count, 2);
    tick();
    ARESET = 1'b1;
    start_push(1'b1, 4'd2, 32'd2);
    tick();
    ARESET    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("t5_count", count, 0);
    check("t5_transfer", transfer, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    tick();
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    repeat (4) tick();
    check("t5_no_rsp", rsp_q.size(), 0);
    check("t5_no_new_xfer", xfer_q.size(), 1);
    check("t5_idle", busy, 0);

    // Simultaneous push and pop at count=2, then wrap the pointers
    rsp_q.delete(); xfer_q.delete();
    push(1'b1, 4'd1, 32'd11);
    tick(); tick();
    push(1'b1, 4'd2, 32'd12);
    push(1'b1, 4'd3, 32'd13);
    @(negedge ACLK);
    check("t6_count2", count, 2);
    tick();
    man_ready = 1'b1;
    tick();
    man_ready   = 1'b0;
    manual_mode = 1'b0;
    tick();
    start_push(1'b1, 4'd4, 32'd14);
    tick();
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("t6_push_pop_count", count, 2);
    check("t6_push_pop_transfer", transfer, 1);
    tick();
    push(1'b1, 4'd5, 32'd15);
    wait_rsp(5);
    check("t6_xfer_count", xfer_q.size(), 5);
    for (int i = 0; i < 5 && i < rsp_q.size() && i < xfer_q.size(); i++) begin
      check("t6_xfer", xfer_q[i], {1'b1, 4'(i + 1), 32'(11 + i)});
      check("t6_rsp", rsp_q[i], {1'b1, 4'(i + 1), 32'd0, 1'b0});
    end
    repeat (3) tick();

`ifdef CMD_SEQ_TIMEOUT_EN
    // Timeout after 8 WAIT cycles, next command proceeds normally
    manual_mode = 1'b1;
    man_ready   = 1'b0;
    rsp_q.delete(); xfer_q.delete();
    push(1'b1, 4'd6, 32'd6);
    start_push(1'b1, 4'd7, 32'd7);
    tick();
    cmd_valid = 1'b0;
    @(negedge ACLK);
    check("t7_transfer", transfer, 1);
    repeat (8) tick();
    @(negedge ACLK);
    check("t7_not_yet", rsp_valid, 0);
    tick();
    @(negedge ACLK);
    check("t7_tmo_valid", rsp_valid, 1);
    check("t7_tmo_err", rsp_err, 1);
    check("t7_tmo_rdata", rsp_rdata, 0);
    manual_mode = 1'b0;
    wait_rsp(2);
    if (rsp_q.size() >= 2) check("t7_next_rsp", rsp_q[1], {1'b1, 4'd7, 32'd0, 1'b0});
    repeat (3) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
